cp0_reg_dump: RTL and testbench

CP0_REG_DUMP -- requirements
Module: cp0_reg_dump

---
 rtl/cp0_pkg.sv | 16 +
 rtl/cp0_flat_decode.sv | 47 ++++
 rtl/cp0_reg_dump.sv | 131 +++++++++++++
 tb/tb_cp0_reg_dump.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants and state encoding for the CP0 register dump sequencer.
package cp0_pkg;

  localparam int CP0_FLAT_LAST = 38;
  localparam int CP0_FLAT_HOLE = 36;
  localparam int CP0_FLAT_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4
  } cp0_state_e;

endpackage

// File: rtl/cp0_flat_decode.sv
// Combinational map from the flat CP0 register index to its architectural (rd, sel) pair.
module cp0_flat_decode
  import cp0_pkg::*;
(
  input  logic [CP0_FLAT_W-1:0] idx,
  output logic [4:0]            rd,
  output logic [3:0]            sel
);

  // Flat index lookup; unused slots (including the hole) decode to (0, 0).
  always_comb begin
    rd  = 5'd0;
    sel = 4'd0;
    case (idx)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
      6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11: begin rd = idx[4:0]; sel = 4'd0; end
      6'd12: begin rd = 5'd12; sel = 4'd1; end
      6'd13: begin rd = 5'd12; sel = 4'd2; end
      6'd14: begin rd = 5'd12; sel = 4'd3; end
      6'd15: begin rd = 5'd12; sel = 4'd0; end
      6'd16: begin rd = 5'd13; sel = 4'd0; end
      6'd17: begin rd = 5'd14; sel = 4'd0; end
      6'd18: begin rd = 5'd15; sel = 4'd1; end
      6'd19: begin rd = 5'd15; sel = 4'd0; end
      6'd20: begin rd = 5'd16; sel = 4'd1; end
      6'd21: begin rd = 5'd16; sel = 4'd2; end
      6'd22: begin rd = 5'd16; sel = 4'd3; end
      6'd23: begin rd = 5'd16; sel = 4'd0; end
      6'd24: begin rd = 5'd17; sel = 4'd0; end
      6'd25: begin rd = 5'd18; sel = 4'd0; end
      6'd26: begin rd = 5'd19; sel = 4'd0; end
      6'd27: begin rd = 5'd23; sel = 4'd0; end
      6'd28: begin rd = 5'd24; sel = 4'd0; end
      6'd29: begin rd = 5'd25; sel = 4'd0; end
      6'd30: begin rd = 5'd25; sel = 4'd1; end
      6'd31: begin rd = 5'd26; sel = 4'd0; end
      6'd32: begin rd = 5'd27; sel = 4'd0; end
      6'd33: begin rd = 5'd28; sel = 4'd1; end
      6'd34: begin rd = 5'd28; sel = 4'd0; end
      6'd35: begin rd = 5'd29; sel = 4'd0; end
      6'd37: begin rd = 5'd30; sel = 4'd0; end
      6'd38: begin rd = 5'd31; sel = 4'd0; end
      default: begin rd = 5'd0; sel = 4'd0; end
    endcase
  end

endmodule

// File: rtl/cp0_reg_dump.sv
// Walks the flat CP0 register file and streams each value out as an (rd, sel, data) record.
module cp0_reg_dump
  import cp0_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LAST_IDX = 38
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  rdEn,
  output logic [CP0_FLAT_W-1:0] rdIdx,
  input  logic [DATA_W-1:0]     rdData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [4:0]            outRd,
  output logic [3:0]            outSel,
  output logic [DATA_W-1:0]     outData,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CP0_FLAT_W-1:0] LAST_L = CP0_FLAT_W'(LAST_IDX);
  localparam logic [CP0_FLAT_W-1:0] HOLE_L = CP0_FLAT_W'(CP0_FLAT_HOLE);

  cp0_state_e            state_r;
  logic [CP0_FLAT_W-1:0] idx_r;
  logic                  rden_r;
  logic [CP0_FLAT_W-1:0] rdidx_r;
  logic                  outvalid_r;
  logic [4:0]            outrd_r;
  logic [3:0]            outsel_r;
  logic [DATA_W-1:0]     outdata_r;
  logic                  busy_r;
  logic                  done_r;

  logic [4:0]            dec_rd_s;
  logic [3:0]            dec_sel_s;
  logic [CP0_FLAT_W-1:0] idx_plus_s;
  logic [CP0_FLAT_W-1:0] next_idx_s;

  cp0_flat_decode u_decode (
    .idx (idx_r),
    .rd  (dec_rd_s),
    .sel (dec_sel_s)
  );

  // Next flat index, stepping over the slot that has no architectural register.
  always_comb begin
    idx_plus_s = idx_r + 6'd1;
    if (idx_plus_s == HOLE_L) begin
      next_idx_s = idx_r + 6'd2;
    end else begin
      next_idx_s = idx_plus_s;
    end
  end

  // Dump sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 6'd0;
      rden_r     <= 1'b0;
      rdidx_r    <= 6'd0;
      outvalid_r <= 1'b0;
      outrd_r    <= 5'd0;
      outsel_r   <= 4'd0;
      outdata_r  <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rden_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            idx_r   <= 6'd0;
            rdidx_r <= 6'd0;
            rden_r  <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          outdata_r  <= rdData;
          outrd_r    <= dec_rd_s;
          outsel_r   <= dec_sel_s;
          outvalid_r <= 1'b1;
          state_r    <= ST_SEND;
        end
        ST_SEND: begin
          // Record and its fields stay frozen until the consumer takes it.
          if (outReady) begin
            outvalid_r <= 1'b0;
            if (idx_r == LAST_L) begin
              done_r  <= 1'b1;
              state_r <= ST_FIN;
            end else begin
              idx_r   <= next_idx_s;
              rdidx_r <= next_idx_s;
              rden_r  <= 1'b1;
              state_r <= ST_READ;
            end
          end
        end
        ST_FIN: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          outvalid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdEn     = rden_r;
  assign rdIdx    = rdidx_r;
  assign outValid = outvalid_r;
  assign outRd    = outrd_r;
  assign outSel   = outsel_r;
  assign outData  = outdata_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_cp0_reg_dump.sv
// Directed bench for cp0_reg_dump: latency, full walk order, hole skip, stall, reset and random backpressure.
module tb_cp0_reg_dump;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              outReady = 1'b1;
  logic              rdEn;
  logic [5:0]        rdIdx;
  logic [DATA_W-1:0] rdData = 32'h0;
  logic              outValid;
  logic [4:0]        outRd;
  logic [3:0]        outSel;
  logic [DATA_W-1:0] outData;
  logic              busy;
  logic              done;

  int pass_cnt  = 0;
  int check_cnt = 0;

  cp0_reg_dump #(.DATA_W(DATA_W), .LAST_IDX(38)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rdEn     (rdEn),
    .rdIdx    (rdIdx),
    .rdData   (rdData),
    .outValid (outValid),
    .outReady (outReady),
    .outRd    (outRd),
    .outSel   (outSel),
    .outData  (outData),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Register file model: synchronous read returning idx * 0x1000.
  always @(posedge clk) begin
    if (rdEn) rdData <= {14'd0, rdIdx, 12'h000};
  end

  // Record capture, done timing, hole reads and hold-stability tracking.
  logic [4:0]  rec_rd   [0:1023];
  logic [3:0]  rec_sel  [0:1023];
  logic [31:0] rec_data [0:1023];
  int rec_cnt = 0, done_cnt = 0, hole_cnt = 0, stable_err = 0;
  int cyc = 0, last_acc_cyc = 0, done_cyc = 0;
  logic pv = 1'b0;
  logic [4:0] prd = 5'd0;
  logic [3:0] psel = 4'd0;
  logic [31:0] pdata = 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (outValid && outReady) begin
      rec_rd[rec_cnt]   <= outRd;
      rec_sel[rec_cnt]  <= outSel;
      rec_data[rec_cnt] <= outData;
      rec_cnt           <= rec_cnt + 1;
      last_acc_cyc      <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rdEn && rdIdx == 6'd36) hole_cnt <= hole_cnt + 1;
    if (pv && !(outValid && outRd == prd && outSel == psel && outData == pdata))
      stable_err <= stable_err + 1;
    pv    <= rst_n && outValid && !outReady;
    prd   <= outRd;
    psel  <= outSel;
    pdata <= outData;
  end

  function automatic logic [8:0] exp_map(input int idx);
    logic [5:0] i6;
    i6 = 6'(idx);
    case (idx)
      0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11: exp_map = {i6[4:0], 4'd0};
      12: exp_map = {5'd12, 4'd1};  13: exp_map = {5'd12, 4'd2};
      14: exp_map = {5'd12, 4'd3};  15: exp_map = {5'd12, 4'd0};
      16: exp_map = {5'd13, 4'd0};  17: exp_map = {5'd14, 4'd0};
      18: exp_map = {5'd15, 4'd1};  19: exp_map = {5'd15, 4'd0};
      20: exp_map = {5'd16, 4'd1};  21: exp_map = {5'd16, 4'd2};
      22: exp_map = {5'd16, 4'd3};  23: exp_map = {5'd16, 4'd0};
      24: exp_map = {5'd17, 4'd0};  25: exp_map = {5'd18, 4'd0};
      26: exp_map = {5'd19, 4'd0};  27: exp_map = {5'd23, 4'd0};
      28: exp_map = {5'd24, 4'd0};  29: exp_map = {5'd25, 4'd0};
      30: exp_map = {5'd25, 4'd1};  31: exp_map = {5'd26, 4'd0};
      32: exp_map = {5'd27, 4'd0};  33: exp_map = {5'd28, 4'd1};
      34: exp_map = {5'd28, 4'd0};  35: exp_map = {5'd29, 4'd0};
      37: exp_map = {5'd30, 4'd0};  38: exp_map = {5'd31, 4'd0};
      default: exp_map = 9'h1FF;
    endcase
  endfunction

  // Number of the 38 records starting at base that differ from the expected walk.
  function automatic int bad_records(input int base);
    int bad, idx;
    bad = 0;
    for (int k = 0; k < 38; k++) begin
      idx = (k < 36) ? k : k + 1;
      if ({rec_rd[base+k], rec_sel[base+k]} !== exp_map(idx) ||
          rec_data[base+k] !== 32'(idx) * 32'h1000) bad++;
    end
    return bad;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; outReady = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++;
    if ({busy, outValid, rdEn, rdIdx, outRd, outSel, outData, done} !== 50'd0)
      $display("FAIL reset_state: got busy=%b v=%b en=%b idx=%0d rd=%0d sel=%0d data=%h done=%b, want all zero",
               busy, outValid, rdEn, rdIdx, outRd, outSel, outData, done);
    else pass_cnt++;
  endtask

  int full_base;

  task automatic test_full_dump();
    bit ok;
    int dbase;
    full_base = rec_cnt; dbase = done_cnt;
    pulse_start();
    check_cnt++;
    if ({rdEn, rdIdx, busy, outValid} !== {1'b1, 6'd0, 1'b1, 1'b0})
      $display("FAIL read_cycle: got en=%b idx=%0d busy=%b v=%b, want 1 0 1 0", rdEn, rdIdx, busy, outValid);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({rdEn, outValid} !== 2'b00)
      $display("FAIL wait_cycle: got en=%b v=%b, want 0 0", rdEn, outValid);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({outValid, outRd, outSel, outData} !== {1'b1, 5'd0, 4'd0, 32'h0})
      $display("FAIL first_record: got v=%b rd=%0d sel=%0d data=%h, want 1 0 0 0", outValid, outRd, outSel, outData);
    else pass_cnt++;
    wait_done(400, ok);
    check_cnt++;
    if (!ok) $display("FAIL full_done: got no done, want done within 400 cycles");
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (rec_cnt - full_base !== 38) $display("FAIL full_count: got %0d records, want 38", rec_cnt - full_base);
    else pass_cnt++;
    check_cnt++;
    if (done_cyc - last_acc_cyc !== 1) $display("FAIL done_timing: got %0d cycles after last accept, want 1", done_cyc - last_acc_cyc);
    else pass_cnt++;
    check_cnt++;
    if (done_cnt - dbase !== 1 || busy !== 1'b0) $display("FAIL done_pulse: got %0d pulses busy=%b, want 1 pulse busy=0", done_cnt - dbase, busy);
    else pass_cnt++;
    check_cnt++;
    if (bad_records(full_base) !== 0) $display("FAIL full_records: got %0d bad records, want 0", bad_records(full_base));
    else pass_cnt++;
  endtask

  task automatic test_hole();
    check_cnt++;
    if ({rec_rd[full_base+35], rec_sel[full_base+35], rec_data[full_base+35]} !== {5'd29, 4'd0, 32'h23000})
      $display("FAIL hole_pre: got %0d/%0d/%h, want 29/0/23000", rec_rd[full_base+35], rec_sel[full_base+35], rec_data[full_base+35]);
    else pass_cnt++;
    check_cnt++;
    if ({rec_rd[full_base+36], rec_sel[full_base+36], rec_data[full_base+36]} !== {5'd30, 4'd0, 32'h25000})
      $display("FAIL hole_post: got %0d/%0d/%h, want 30/0/25000", rec_rd[full_base+36], rec_sel[full_base+36], rec_data[full_base+36]);
    else pass_cnt++;
    check_cnt++;
    if ({rec_rd[full_base+37], rec_sel[full_base+37], rec_data[full_base+37]} !== {5'd31, 4'd0, 32'h26000})
      $display("FAIL hole_last: got %0d/%0d/%h, want 31/0/26000", rec_rd[full_base+37], rec_sel[full_base+37], rec_data[full_base+37]);
    else pass_cnt++;
    check_cnt++;
    if (hole_cnt !== 0) $display("FAIL hole_read: got %0d reads of idx 36, want 0", hole_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    bit ok, found;
    int base, serr, v_err, f_err, en_err;
    base = rec_cnt; serr = stable_err; found = 1'b0;
    v_err = 0; f_err = 0; en_err = 0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (outValid && outRd == 5'd12 && outSel == 4'd1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check_cnt++;
    if (!found) $display("FAIL stall_find: got no record rd=12 sel=1, want one");
    else pass_cnt++;
    outReady = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (outValid !== 1'b1) v_err++;
      if ({outRd, outSel, outData} !== {5'd12, 4'd1, 32'h0000C000}) f_err++;
      if (rdEn !== 1'b0) en_err++;
    end
    check_cnt++;
    if (v_err !== 0) $display("FAIL stall_valid: got %0d low cycles, want 0", v_err);
    else pass_cnt++;
    check_cnt++;
    if (f_err !== 0) $display("FAIL stall_fields: got %0d changed cycles (rd=%0d sel=%0d data=%h), want 0", f_err, outRd, outSel, outData);
    else pass_cnt++;
    check_cnt++;
    if (en_err !== 0) $display("FAIL stall_rden: got %0d rdEn cycles, want 0", en_err);
    else pass_cnt++;
    outReady = 1'b1;
    wait_done(400, ok);
    repeat (2) @(negedge clk);
    check_cnt++;
    if (!ok || rec_cnt - base !== 38 || bad_records(base) !== 0)
      $display("FAIL stall_dump: got done=%b count=%0d, want done=1 count=38 all correct", ok, rec_cnt - base);
    else pass_cnt++;
    check_cnt++;
    if (stable_err - serr !== 0) $display("FAIL stall_hold: got %0d unstable cycles, want 0", stable_err - serr);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    bit ok, found;
    int base, dbase;
    base = rec_cnt; dbase = done_cnt; found = 1'b0;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (outValid && outRd == 5'd5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, ok);
    repeat (6) @(negedge clk);
    check_cnt++;
    if (!found || !ok || rec_cnt - base !== 38 || bad_records(base) !== 0)
      $display("FAIL start_ignored: got found=%b done=%b count=%0d, want 1 1 38", found, ok, rec_cnt - base);
    else pass_cnt++;
    check_cnt++;
    if (done_cnt - dbase !== 1 || busy !== 1'b0)
      $display("FAIL start_done: got %0d pulses busy=%b, want 1 pulse busy=0", done_cnt - dbase, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    int base;
    found = 1'b0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (rdEn && rdIdx == 6'd20) begin found = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cnt++;
    if (!found || {busy, outValid, rdIdx, rdEn, done, outRd, outSel, outData} !== 50'd0)
      $display("FAIL mid_reset: got found=%b busy=%b v=%b idx=%0d en=%b done=%b, want 1 0 0 0 0 0",
               found, busy, outValid, rdIdx, rdEn, done);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    check_cnt++;
    if (busy !== 1'b0 || rdEn !== 1'b0) $display("FAIL no_resume: got busy=%b en=%b, want 0 0", busy, rdEn);
    else pass_cnt++;
    base = rec_cnt;
    pulse_start();
    check_cnt++;
    if (rdEn !== 1'b1 || rdIdx !== 6'd0) $display("FAIL restart_idx: got en=%b idx=%0d, want 1 0", rdEn, rdIdx);
    else pass_cnt++;
    wait_done(400, ok);
    repeat (2) @(negedge clk);
    check_cnt++;
    if (!ok || rec_cnt - base !== 38 || bad_records(base) !== 0)
      $display("FAIL restart_dump: got done=%b count=%0d, want 1 38", ok, rec_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit ok;
    int base, serr;
    base = rec_cnt; serr = stable_err; ok = 1'b0;
    void'($urandom(32'd1234));
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      outReady = 1'($urandom_range(0, 1));
    end
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (!ok || rec_cnt - base !== 38) $display("FAIL random_count: got done=%b count=%0d, want 1 38", ok, rec_cnt - base);
    else pass_cnt++;
    check_cnt++;
    if (bad_records(base) !== 0) $display("FAIL random_records: got %0d bad, want 0", bad_records(base));
    else pass_cnt++;
    check_cnt++;
    if (stable_err - serr !== 0) $display("FAIL random_hold: got %0d unstable cycles, want 0", stable_err - serr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_hole();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
